// File: rtl/wb_timer_slave.sv
// rtl/wb_timer_slave.sv - Wishbone-mapped up/down timer with compare, auto-reload, LA load and IRQ
module wb_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 32,
    parameter int          IO_W      = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic [63:0]       la_data_in,
    input  logic [63:0]       la_oenb,
    output logic [31:0]       la_data_out,
    output logic [IO_W-1:0]   io_out,
    output logic [IO_W-1:0]   io_oeb,
    output logic [2:0]        irq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [4:0]       ctrl;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cmp;
    logic             pend;
    logic             ack;
    logic [31:0]      dat;

    logic             hit;
    logic             req;
    logic             wr;
    logic [1:0]       offset;
    logic [31:0]      count_ext;
    logic [31:0]      cmp_ext;
    logic [31:0]      rd_data;
    logic [31:0]      wr_merge;
    logic             wr_count;
    logic             la_load;
    logic             step_en;
    logic             match;
    logic [CNT_W-1:0] count_step;
    logic             unused_bits;

    assign hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // The ~ack term forces an idle cycle between accesses so a held strobe is served once.
    assign req      = wbs_cyc_i & wbs_stb_i & hit & ~ack;
    assign wr       = req & wbs_we_i;
    assign offset   = wbs_adr_i[3:2];
    assign wr_count = wr & (offset == 2'd1);
    assign la_load  = la_data_in[32] & ~la_oenb[32];
    assign step_en  = ctrl[0] & ~wr_count & ~la_load;

    always_comb begin
        count_ext = '0;
        cmp_ext   = '0;
        count_ext[CNT_W-1:0] = count;
        cmp_ext[CNT_W-1:0]   = cmp;
    end

    // Current register value, used both as read data and as the base for byte-lane merges.
    always_comb begin
        rd_data = '0;
        case (offset)
            2'd0:    rd_data = {27'b0, ctrl};
            2'd1:    rd_data = count_ext;
            2'd2:    rd_data = cmp_ext;
            default: rd_data = {31'b0, pend};
        endcase
        wr_merge = rd_data;
        for (int i = 0; i < 4; i++) begin
            if (wbs_sel_i[i]) wr_merge[8*i +: 8] = wbs_dat_i[8*i +: 8];
        end
    end

    always_comb begin
        match      = 1'b0;
        count_step = count;
        if (!ctrl[1]) begin
            match      = (count == cmp);
            count_step = (match && ctrl[2]) ? '0 : count + ONE;
        end else begin
            match      = (count == '0);
            count_step = match ? (ctrl[2] ? cmp : '1) : count - ONE;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ctrl  <= '0;
            count <= '0;
            cmp   <= '0;
            pend  <= 1'b0;
            ack   <= 1'b0;
            dat   <= '0;
        end else begin
            ack <= req;
            if (req && !wbs_we_i) dat <= rd_data;
            if (wr && offset == 2'd0 && wbs_sel_i[0]) ctrl <= wr_merge[4:0];
            if (wr && offset == 2'd2) cmp <= wr_merge[CNT_W-1:0];
            if (wr_count) begin
                count <= wr_merge[CNT_W-1:0];
            end else if (la_load) begin
                count <= la_data_in[CNT_W-1:0];
            end else if (ctrl[0]) begin
                count <= count_step;
            end
            // A match outranks a same-cycle clear so no event is lost.
            if (step_en && match) begin
                pend <= 1'b1;
            end else if (wr && offset == 2'd3 && wbs_sel_i[0] && wbs_dat_i[0]) begin
                pend <= 1'b0;
            end
        end
    end

    assign wbs_ack_o   = ack;
    assign wbs_dat_o   = dat;
    assign la_data_out = count_ext;
    assign io_out      = count[IO_W-1:0];
    assign io_oeb      = {IO_W{~ctrl[4]}};
    assign irq         = {2'b00, pend & ctrl[3]};

    assign unused_bits = ^{la_data_in[63:33], la_oenb[63:33], la_oenb[31:0], wbs_adr_i[1:0]};

endmodule
